hap_sram_fetch_ctrl: RTL and testbench
======================================

Name: hap_sram_fetch_ctrl

Overview:
- Sequences the haplotype SRAM: shares its single port between a host write (load) requester and a read-fetch engine.
- Fetch engine streams a contiguous run of haplotype words to the Pair-HMM PE array over a valid/ready interface.
- Hides the SRAM's fixed read latency and applies credit-based backpressure through a small output FIFO.
- Sits between the pattern loader / PE-array scheduler and the haplotype SRAM instance.

Parameters:
- ADDR_W, $clog2(`HAP_SRAM_WORD_AMOUNT), SRAM word-address width
- DATA_W, `HAP_SRAM_BIT_PER_WORD, SRAM word width
- LEN_W, ADDR_W+1, width of the fetch length field; allows a full-memory fetch
- FIFO_DEPTH, 8, output FIFO entries; power of two, >= 4

Ports:
- clk  in  1  single clock; SRAM clka is driven from the same net
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  host write request
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- cmd_valid  in  1  fetch command request
- cmd_ready  out  1  fetch command accepted this cycle
- cmd_addr  in  ADDR_W  first word address
- cmd_len  in  LEN_W  number of words to fetch; 0 is legal
- hap_valid  out  1  output word valid
- hap_ready  in  1  consumer ready
- hap_data  out  DATA_W  haplotype word
- hap_last  out  1  marks the final word of the command
- done  out  1  one-cycle pulse at command completion
- busy  out  1  high whenever state != IDLE
- sram_wea  out  1  to SRAM wea
- sram_addra  out  ADDR_W  to SRAM addra
- sram_dina  out  DATA_W  to SRAM dina
- sram_douta  in  DATA_W  from SRAM douta

Behaviour:
- Reset: all outputs 0 (sram_*, hap_*, done, busy, wr_ready, cmd_ready).
- Reset state: IDLE; FIFO empty; in-flight pipe cleared; counters 0.
- Reset mid-fetch: abandons the command. Read data already in flight is discarded because the valid pipe is cleared.
- sram_wea, sram_addra and sram_dina are registered.
  - Read issued (decided) in cycle t → sram_addra valid in t+1 → SRAM registers at end of t+1 → douta valid in t+3, captured into the FIFO at end of t+3.
  - The 3-stage rd_vld shift register tracks in-flight reads.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - wr_ready = 1 whenever in IDLE.
  - cmd_ready = !wr_valid; a write has priority over a command in the same cycle.
  - Accepted write: sram_wea=1, addra/dina loaded next cycle, single cycle. Back-to-back writes are allowed.
  - Accepted command: latch base=cmd_addr and remaining=cmd_len.
    - remaining==0 → DONE.
    - otherwise → FETCH.
- FETCH:
  - Issue a read when inflight + fifo_count < FIFO_DEPTH. A same-cycle pop is not credited (conservative).
  - On each issue: addr increments modulo 2^ADDR_W (wraps from max to 0), remaining decrements.
  - The issue that brings remaining to 0 tags that read as last → DRAIN.
  - sram_wea stays 0; writes are blocked (wr_ready=0) outside IDLE.
- DRAIN:
  - Waits for the pop of the word with hap_last=1 (hap_valid & hap_ready & hap_last) → DONE.
- DONE:
  - done=1 for exactly one cycle, then → IDLE.
  - A new command can be accepted in the cycle after DONE.
- FIFO entry is {last, data}.
  - hap_valid = !empty; hap_data and hap_last come from the head, first-word-fall-through.
  - hap_data must hold stable while hap_valid & !hap_ready.
  - Overflow is impossible by the credit rule. Assert fifo_count <= FIFO_DEPTH.
- With hap_ready held at 1, sustained throughput is one word per cycle after a 4-cycle initial latency (cmd accept → first hap_valid).
- The SRAM writes at the second edge after wea is driven. A read issued one cycle after a write to the same address returns the new data, so no hazard exists.

Decomposition:
- hap_sram_pkg: ADDR_W/DATA_W/LEN_W localparams derived from the HAP_SRAM macros; fetch_state_e enum {IDLE, FETCH, DRAIN, DONE}; RD_LAT=3 constant.
- Sub-module hap_sync_fifo (width DATA_W+1, depth FIFO_DEPTH): count output, FWFT head, asynchronous active-low reset.

Test Plan:
- Write addr 0..3 with 0x11,0x22,0x33,0x44, then cmd addr=0 len=4 with hap_ready=1 → hap_data 0x11..0x44 on consecutive cycles, first hap_valid 4 cycles after cmd accept, hap_last only on 0x44, done pulse one cycle after the last pop.
- cmd len=0 → no sram reads, done pulses the cycle after accept, hap_valid never asserts.
- cmd addr=WORDS-2 len=4 → reads addresses WORDS-2, WORDS-1, 0, 1 (wrap), data in that order.
- cmd len=20 with hap_ready toggling 1-cycle-on/3-off → all 20 words in order, no drops or duplicates, fifo_count never > 8, hap_data stable while stalled.
- wr_valid and cmd_valid asserted together in IDLE → write accepted first (cmd_ready=0), command accepted next cycle, fetch returns the newly written value; wr_ready=0 while busy.
- rst_n pulsed low mid-FETCH with 3 reads in flight → all outputs 0 immediately, FIFO empty, no hap_valid after release; a new command then completes normally.

Source files
------------

// File: rtl/hap_sram_pkg.sv
// Shared constants and types for the haplotype SRAM fetch controller.
`ifndef HAP_SRAM_WORD_AMOUNT
`define HAP_SRAM_WORD_AMOUNT 64
`endif
`ifndef HAP_SRAM_BIT_PER_WORD
`define HAP_SRAM_BIT_PER_WORD 32
`endif

package hap_sram_pkg;

    localparam int WORDS  = `HAP_SRAM_WORD_AMOUNT;
    localparam int ADDR_W = $clog2(WORDS);
    localparam int DATA_W = `HAP_SRAM_BIT_PER_WORD;
    localparam int LEN_W  = ADDR_W + 1;

    // Cycles from a registered read address to data on douta, plus the issue stage.
    localparam int RD_LAT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

    // Number of reads currently travelling through the read-latency pipe.
    function automatic logic [2:0] pipe_count(input logic [RD_LAT-1:0] vld);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            n = n + {2'd0, vld[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/hap_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and occupancy count.
module hap_sync_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests so a stray push when full or pop when empty cannot corrupt state.
    always_comb begin
        do_push_s = push & (count_r != CNT_DEPTH);
        do_pop_s  = pop & (count_r != {CNT_W{1'b0}});
    end

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;

    hap_sync_fifo_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count_r)
    );

endmodule

// Occupancy invariant for the FIFO.
module hap_sync_fifo_chk #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             rst_n,
    input logic [CNT_W-1:0] count
);

    // Occupancy must never exceed capacity.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count <= CNT_W'(DEPTH)) else $error("fifo occupancy above capacity");
        end
    end

endmodule

// File: rtl/hap_sram_fetch_ctrl.sv
// Shares the haplotype SRAM port between host writes and a streaming read-fetch engine.
module hap_sram_fetch_ctrl
    import hap_sram_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              hap_valid,
    input  logic              hap_ready,
    output logic [DATA_W-1:0] hap_data,
    output logic              hap_last,
    output logic              done,
    output logic              busy,
    output logic              sram_wea,
    output logic [ADDR_W-1:0] sram_addra,
    output logic [DATA_W-1:0] sram_dina,
    input  logic [DATA_W-1:0] sram_douta
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W = CNT_W + 2;

    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CRD_W-1:0]  CRD_LIMIT = CRD_W'(FIFO_DEPTH);

    fetch_state_e       state_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [LEN_W-1:0]   remaining_r;
    logic               rdy_r;
    logic               done_r;
    logic               busy_r;
    logic [RD_LAT-1:0]  rd_vld_r;
    logic [RD_LAT-1:0]  rd_last_r;
    logic               sram_wea_r;
    logic [ADDR_W-1:0]  sram_addra_r;
    logic [DATA_W-1:0]  sram_dina_r;

    logic [CNT_W-1:0]   fifo_count_s;
    logic               fifo_empty_s;
    logic [DATA_W:0]    fifo_head_s;
    logic [CRD_W-1:0]   credit_used_s;
    logic               credit_ok_s;
    logic               wr_accept_s;
    logic               cmd_accept_s;
    logic               issue_s;
    logic               issue_last_s;
    logic [ADDR_W-1:0]  issue_addr_s;
    logic               pop_s;

    // Handshakes and the read-issue decision; a same-cycle pop earns no credit.
    always_comb begin
        wr_accept_s   = rdy_r & wr_valid;
        cmd_accept_s  = rdy_r & ~wr_valid & cmd_valid;
        credit_used_s = {{(CRD_W-3){1'b0}}, pipe_count(rd_vld_r)} + {2'b00, fifo_count_s};
        credit_ok_s   = (credit_used_s < CRD_LIMIT);
        pop_s         = ~fifo_empty_s & hap_ready;
        issue_s       = 1'b0;
        issue_last_s  = 1'b0;
        issue_addr_s  = addr_r;
        if (cmd_accept_s && (cmd_len != LEN_ZERO) && credit_ok_s) begin
            issue_s      = 1'b1;
            issue_last_s = (cmd_len == LEN_ONE);
            issue_addr_s = cmd_addr;
        end else if ((state_r == FETCH) && credit_ok_s) begin
            issue_s      = 1'b1;
            issue_last_s = (remaining_r == LEN_ONE);
            issue_addr_s = addr_r;
        end else begin
            issue_s      = 1'b0;
            issue_last_s = 1'b0;
            issue_addr_s = addr_r;
        end
    end

    // Registered SRAM port: a write or a read address, never both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_wea_r   <= 1'b0;
            sram_addra_r <= {ADDR_W{1'b0}};
            sram_dina_r  <= {DATA_W{1'b0}};
        end else if (wr_accept_s) begin
            sram_wea_r   <= 1'b1;
            sram_addra_r <= wr_addr;
            sram_dina_r  <= wr_data;
        end else if (issue_s) begin
            sram_wea_r   <= 1'b0;
            sram_addra_r <= issue_addr_s;
        end else begin
            sram_wea_r   <= 1'b0;
        end
    end

    // In-flight read tracker; clearing it on reset discards data still in the SRAM pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_r  <= {RD_LAT{1'b0}};
            rd_last_r <= {RD_LAT{1'b0}};
        end else begin
            rd_vld_r  <= {rd_vld_r[RD_LAT-2:0], issue_s};
            rd_last_r <= {rd_last_r[RD_LAT-2:0], issue_s & issue_last_s};
        end
    end

    // Fetch sequencer with registered ready/done/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            remaining_r <= LEN_ZERO;
            rdy_r       <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (wr_accept_s) begin
                        rdy_r  <= 1'b1;
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end else if (cmd_accept_s) begin
                        rdy_r  <= 1'b0;
                        busy_r <= 1'b1;
                        if (cmd_len == LEN_ZERO) begin
                            state_r     <= DONE;
                            done_r      <= 1'b1;
                            addr_r      <= cmd_addr;
                            remaining_r <= LEN_ZERO;
                        end else if (issue_s) begin
                            done_r      <= 1'b0;
                            addr_r      <= cmd_addr + ADDR_ONE;
                            remaining_r <= cmd_len - LEN_ONE;
                            if (cmd_len == LEN_ONE) begin
                                state_r <= DRAIN;
                            end else begin
                                state_r <= FETCH;
                            end
                        end else begin
                            done_r      <= 1'b0;
                            addr_r      <= cmd_addr;
                            remaining_r <= cmd_len;
                            state_r     <= FETCH;
                        end
                    end else begin
                        rdy_r  <= 1'b1;
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                end
                FETCH: begin
                    rdy_r  <= 1'b0;
                    busy_r <= 1'b1;
                    done_r <= 1'b0;
                    if (issue_s) begin
                        addr_r      <= addr_r + ADDR_ONE;
                        remaining_r <= remaining_r - LEN_ONE;
                        if (remaining_r == LEN_ONE) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= FETCH;
                        end
                    end else begin
                        state_r <= FETCH;
                    end
                end
                DRAIN: begin
                    rdy_r  <= 1'b0;
                    busy_r <= 1'b1;
                    if (pop_s && fifo_head_s[DATA_W]) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    rdy_r   <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    rdy_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    hap_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_vld_r[RD_LAT-1]),
        .push_data ({rd_last_r[RD_LAT-1], sram_douta}),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Present the FIFO head; force zeros while empty so idle outputs stay clean.
    always_comb begin
        if (fifo_empty_s) begin
            hap_data = {DATA_W{1'b0}};
            hap_last = 1'b0;
        end else begin
            hap_data = fifo_head_s[DATA_W-1:0];
            hap_last = fifo_head_s[DATA_W];
        end
    end

    assign hap_valid  = ~fifo_empty_s;
    assign wr_ready   = rdy_r;
    assign cmd_ready  = rdy_r & ~wr_valid;
    assign done       = done_r;
    assign busy       = busy_r;
    assign sram_wea   = sram_wea_r;
    assign sram_addra = sram_addra_r;
    assign sram_dina  = sram_dina_r;

endmodule

// File: tb/tb_hap_sram_fetch_ctrl.sv
// Scoreboard bench for hap_sram_fetch_ctrl with a behavioural SRAM and reference memory.
module tb_hap_sram_fetch_ctrl;
    import hap_sram_pkg::*;

    localparam int DEPTH = 8;

    logic              clk;
    logic              rst_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              hap_valid;
    logic              hap_ready;
    logic [DATA_W-1:0] hap_data;
    logic              hap_last;
    logic              done;
    logic              busy;
    logic              sram_wea;
    logic [ADDR_W-1:0] sram_addra;
    logic [DATA_W-1:0] sram_dina;
    logic [DATA_W-1:0] sram_douta;

    hap_sram_fetch_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .hap_valid(hap_valid), .hap_ready(hap_ready), .hap_data(hap_data), .hap_last(hap_last),
        .done(done), .busy(busy),
        .sram_wea(sram_wea), .sram_addra(sram_addra), .sram_dina(sram_dina), .sram_douta(sram_douta)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t              exp_q[$];
    int                done_q[$];
    logic [DATA_W-1:0] ref_mem [WORDS];
    int                vectors = 0;
    int                miscompares = 0;
    int                cyc = 0;
    int                ready_mode = 0;

    // SRAM: write at the edge that samples wea, registered address, registered output.
    logic [DATA_W-1:0] sram_mem [WORDS];
    logic [ADDR_W-1:0] sram_rd_addr;
    logic [DATA_W-1:0] sram_q;
    always @(posedge clk) begin
        if (sram_wea) sram_mem[sram_addra] <= sram_dina;
        sram_rd_addr <= sram_addra;
        sram_q       <= sram_mem[sram_rd_addr];
    end
    assign sram_douta = sram_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer ready pattern.
    initial begin
        int ph;
        ph = 0;
        hap_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: hap_ready = 1'b1;
                1: begin
                    hap_ready = (ph == 0);
                    ph = (ph + 1) % 4;
                end
                2: hap_ready = 1'($urandom_range(0, 1));
                default: hap_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare popped words, stall stability, FIFO bound and done pulses.
    initial begin
        bit                stalled;
        logic [DATA_W-1:0] held_d;
        logic              held_l;
        bit                exp_done;
        exp_t              e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_valid", 64'(hap_valid), 64'd1);
                    chk("stall_word", 64'({hap_last, hap_data}), 64'({held_l, held_d}));
                end
                if (hap_valid) chk("fifo_bound", 64'(dut.fifo_count_s <= DEPTH), 64'd1);
                exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
                if (exp_done) void'(done_q.pop_front());
                if (done || exp_done) chk("done_pulse", 64'(done), 64'(exp_done));
                if (hap_valid && hap_ready) begin
                    chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("hap_data", 64'(hap_data), 64'(e.data));
                        chk("hap_last", 64'(hap_last), 64'(e.last));
                        if (e.last) done_q.push_back(cyc + 1);
                    end
                    stalled = 1'b0;
                end else if (hap_valid) begin
                    stalled = 1'b1;
                    held_d  = hap_data;
                    held_l  = hap_last;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit got;
        got = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (wr_ready) begin
                got = 1'b1;
                ref_mem[a] = d;
            end
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        chk("wr_accept", 64'(got), 64'd1);
    endtask

    task automatic do_cmd(input logic [ADDR_W-1:0] a, input int len, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = LEN_W'(len);
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                acc = cyc;
                for (int i = 0; i < len; i++)
                    exp_q.push_back('{ref_mem[(int'(a) + i) % WORDS], (i == len - 1)});
                if (len == 0) done_q.push_back(cyc + 1);
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", 64'(got), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && (done_q.size() == 0) && !busy;
        end
        chk("drain_complete", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({hap_valid, hap_last, done, busy, wr_ready, cmd_ready, sram_wea}), 64'd0);
        chk({tag, "_addra"}, 64'(sram_addra), 64'd0);
        chk({tag, "_dina"}, 64'(sram_dina), 64'd0);
        chk({tag, "_hapdata"}, 64'(hap_data), 64'd0);
    endtask

    initial begin
        int acc;
        logic [DATA_W-1:0] v;
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        for (int i = 0; i < WORDS; i++) begin
            v = DATA_W'($urandom);
            sram_mem[i] <= v;
            ref_mem[i] = v;
        end
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic stream with latency check.
        do_write(ADDR_W'(0), DATA_W'(32'h11));
        do_write(ADDR_W'(1), DATA_W'(32'h22));
        do_write(ADDR_W'(2), DATA_W'(32'h33));
        do_write(ADDR_W'(3), DATA_W'(32'h44));
        do_cmd(ADDR_W'(0), 4, acc);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
                @(negedge clk);
                seen = hap_valid;
            end
            chk("first_latency", 64'(cyc - acc), 64'd4);
        end
        wait_idle();

        // Zero-length command.
        do_cmd(ADDR_W'(5), 0, acc);
        wait_idle();

        // Address wrap.
        do_write(ADDR_W'(WORDS - 2), DATA_W'(32'hAA));
        do_write(ADDR_W'(WORDS - 1), DATA_W'(32'hBB));
        do_cmd(ADDR_W'(WORDS - 2), 4, acc);
        wait_idle();

        // Long fetch against a 1-on/3-off consumer.
        ready_mode = 1;
        do_cmd(ADDR_W'($urandom_range(0, WORDS - 1)), 20, acc);
        wait_idle();
        ready_mode = 0;

        // Simultaneous write and command: write wins, command follows.
        wr_valid = 1'b1; wr_addr = ADDR_W'(9); wr_data = DATA_W'(32'h5A5A_0F0F);
        cmd_valid = 1'b1; cmd_addr = ADDR_W'(9); cmd_len = LEN_W'(1);
        @(negedge clk);
        chk("both_wr_ready", 64'(wr_ready), 64'd1);
        chk("both_cmd_ready", 64'(cmd_ready), 64'd0);
        if (wr_ready) ref_mem[9] = DATA_W'(32'h5A5A_0F0F);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("cmd_after_wr", 64'(cmd_ready), 64'd1);
        if (cmd_ready) exp_q.push_back('{ref_mem[9], 1'b1});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wr_valid = 1'b1; wr_addr = ADDR_W'(10); wr_data = DATA_W'(32'h1);
        @(negedge clk);
        chk("busy_flag", 64'(busy), 64'd1);
        chk("wr_blocked", 64'(wr_ready), 64'd0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a fetch with reads in flight.
        ready_mode = 3;
        do_cmd(ADDR_W'(5), 10, acc);
        @(negedge clk);
        @(posedge clk); #1;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_q.delete();
        done_q.delete();
        ready_mode = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("post_reset_quiet", 64'(hap_valid), 64'd0);
        end
        @(posedge clk); #1;
        do_cmd(ADDR_W'(3), 6, acc);
        wait_idle();

        // Randomized mix of writes and fetches under random backpressure.
        ready_mode = 2;
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 2) == 0)
                do_write(ADDR_W'($urandom_range(0, WORDS - 1)), DATA_W'($urandom));
            else
                do_cmd(ADDR_W'($urandom_range(0, WORDS - 1)), $urandom_range(0, 24), acc);
        end
        wait_idle();
        ready_mode = 0;

        chk("final_words_left", 64'(exp_q.size()), 64'd0);
        chk("final_done_left", 64'(done_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
